// File: rtl/sequential_divider_if.sv
// sequential_divider_if: operand/result bundle for the sequential divider
interface sequential_divider_if #(
  parameter int WIDTH_DVD = 10,
  parameter int WIDTH_DVS = 5
);
  logic                 start;
  logic [WIDTH_DVD-1:0] dividend;
  logic [WIDTH_DVS-1:0] divisor;
  logic [WIDTH_DVD-1:0] quotient;
  logic [WIDTH_DVS-1:0] remainder;
  logic                 busy;
  logic                 ready;
  logic                 div_zero;
  logic                 ovf;
  modport master (output start, dividend, divisor, input quotient, remainder, busy, ready, div_zero, ovf);
  modport slave  (input start, dividend, divisor, output quotient, remainder, busy, ready, div_zero, ovf);
endinterface

// File: rtl/sequential_divider.sv
// sequential_divider: signed restoring divider, one quotient bit per clock
module sequential_divider #(
  parameter int WIDTH_DVD = 10,
  parameter int WIDTH_DVS = 5
) (
  input logic clk,
  input logic rst,
  sequential_divider_if.slave bus
);
  localparam int WD = WIDTH_DVD;
  localparam int WS = WIDTH_DVS;
  localparam int CW = $clog2(WD);
  typedef enum logic [1:0] {IDLE, DIVIDE, SIGN, DONE} state_t;
  state_t state_q, state_d;
  logic [WD-1:0] a_q, a_d, q_q, q_d;
  logic [WS-1:0] b_q, b_d, r_q, r_d;
  logic [WS:0]   p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sq_q, sq_d, sr_q, sr_d, zp_q, zp_d;
  logic busy_q, busy_d, ready_q, ready_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [WS+1:0] sh;
  logic [WS+2:0] diff;
  logic          ge, sat;
  assign sh   = {p_q, a_q[WD-1]};
  assign diff = {1'b0, sh} - (WS+3)'(b_q);
  assign ge   = ~diff[WS+2];
  // q_mag of 2^(WD-1) is only legal when the result is negative
  assign sat  = a_q[WD-1] & ~sq_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    zp_d    = zp_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (bus.start) begin
        a_d     = bus.dividend[WD-1] ? -bus.dividend : bus.dividend;
        b_d     = bus.divisor[WS-1] ? -bus.divisor : bus.divisor;
        sq_d    = bus.dividend[WD-1] ^ bus.divisor[WS-1];
        sr_d    = bus.dividend[WD-1];
        p_d     = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        zp_d    = bus.divisor == '0;
        state_d = zp_d ? DONE : DIVIDE;
      end
      DIVIDE: begin
        p_d     = (WS+1)'(ge ? diff[WS+1:0] : sh);
        a_d     = {a_q[WD-2:0], ge};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WD-1) ? SIGN : DIVIDE;
      end
      SIGN: begin
        q_d     = sat ? {1'b0, {(WD-1){1'b1}}} : (sq_q ? -a_q : a_q);
        r_d     = sr_q ? -p_q[WS-1:0] : p_q[WS-1:0];
        ovf_d   = sat;
        dz_d    = 1'b0;
        ready_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (zp_q) begin
        q_d     = '0;
        r_d     = '0;
        dz_d    = 1'b1;
        ovf_d   = 1'b0;
        ready_d = 1'b1;
        zp_d    = 1'b0;
      end else begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      zp_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      zp_q    <= zp_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.quotient  = q_q;
  assign bus.remainder = r_q;
  assign bus.busy      = busy_q;
  assign bus.ready     = ready_q;
  assign bus.div_zero  = dz_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: directed and random operations against an arithmetic reference
module tb_sequential_divider;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  sequential_divider_if #(.WIDTH_DVD(10), .WIDTH_DVS(5)) bus();
  sequential_divider #(.WIDTH_DVD(10), .WIDTH_DVS(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [9:0] d, input logic [4:0] v,
                                output logic [9:0] q, output logic [4:0] r,
                                output logic z, output logic o);
    int a, b, qi;
    a = $signed(d);
    b = $signed(v);
    z = 1'b0;
    o = 1'b0;
    q = '0;
    r = '0;
    if (b == 0) z = 1'b1;
    else begin
      qi = a / b;
      r  = 5'(a % b);
      if (qi > 511) begin
        qi = 511;
        o  = 1'b1;
      end
      q = 10'(qi);
    end
  endfunction
  task automatic check_zero(input string tag);
    check({tag, "_q"}, bus.quotient, 0);
    check({tag, "_r"}, bus.remainder, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_ready"}, bus.ready, 0);
    check({tag, "_dz"}, bus.div_zero, 0);
    check({tag, "_ovf"}, bus.ovf, 0);
  endtask
  // mode: 0 plain, 1 disturb inputs mid-run, 2 async reset mid-run, 3 start held high
  task automatic run_op(input logic [9:0] d, input logic [4:0] v, input int mode);
    logic [9:0] eq, hq;
    logic [4:0] er;
    logic ez, eo;
    int n, extra;
    model(d, v, eq, er, ez, eo);
    hq = bus.quotient;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = d;
    bus.divisor = v;
    @(posedge clk);
    @(negedge clk);
    if (mode != 3) bus.start = 1'b0;
    check("busy_e0", bus.busy, 1);
    for (n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (mode == 1 && n == 2) bus.dividend = 10'd300;
      if (mode == 1 && n == 3) begin
        bus.start = 1'b1;
        bus.dividend = 10'd50;
        bus.divisor = 5'd5;
      end
      if (mode == 1 && n == 4) bus.start = 1'b0;
      if (mode == 2 && n == 5) begin
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (bus.ready) break;
      if (n == 5) begin
        check("hold_q", bus.quotient, hq);
        check("busy_mid", bus.busy, 1);
      end
    end
    check("latency", n, ez ? 1 : 11);
    check("quot", bus.quotient, eq);
    check("rem", bus.remainder, er);
    check("dz", bus.div_zero, ez);
    check("ovf", bus.ovf, eo);
    @(posedge clk);
    @(negedge clk);
    check("ready_drop", bus.ready, 0);
    check("busy_drop", bus.busy, 0);
    if (mode == 1) begin
      extra = 0;
      repeat (14) begin
        @(negedge clk);
        extra += int'(bus.ready);
      end
      check("no_2nd_ready", extra, 0);
      check("quot_kept", bus.quotient, eq);
    end
    if (mode == 3) begin
      @(negedge clk);
      check("b2b_busy", bus.busy, 1);
      bus.start = 1'b0;
      for (n = 1; n <= 30 && !bus.ready; n++) @(negedge clk);
      check("b2b_quot", bus.quotient, eq);
      check("b2b_rem", bus.remainder, er);
      @(negedge clk);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    run_op(10'd100, 5'd7, 0);
    run_op(10'h39C, 5'd7, 0);
    run_op(10'd100, 5'h10, 0);
    run_op(10'h200, 5'h1F, 0);
    run_op(10'h200, 5'd1, 0);
    run_op(10'd37, 5'd0, 0);
    run_op(10'd37, 5'd5, 0);
    run_op(10'd100, 5'd7, 1);
    run_op(10'd100, 5'd7, 2);
    run_op(10'd9, 5'd3, 0);
    run_op(10'h1FF, 5'h10, 0);
    run_op(10'd123, 5'h1C, 3);
    repeat (40) run_op(10'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
Sequential signed restoring divider. It computes quotient and remainder from a two's-complement dividend and divisor, one quotient bit per clock. It is the inverse datapath of the board's shift-add multiplier and sits beside it. It uses the same operand split: the 10-bit switch bus supplies the dividend, a 5-bit field supplies the divisor. Its quotient feeds the existing complement mux, BCD converter and 7-segment path.

Parameters:
WIDTH_DVD, 10, dividend and quotient width (signed two's complement)
WIDTH_DVS, 5, divisor and remainder width (signed two's complement)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  active-high request; sampled only in IDLE
dividend  input  WIDTH_DVD  signed dividend; captured on the accepting edge only
divisor  input  WIDTH_DVS  signed divisor; captured on the accepting edge only
quotient  output  WIDTH_DVD  signed quotient, truncated toward zero
remainder  output  WIDTH_DVS  signed remainder; sign follows dividend
busy  output  1  high from the accepting edge until ready drops
ready  output  1  one-cycle pulse; results valid and stable from this cycle on
div_zero  output  1  divisor was 0 for the last completed operation
ovf  output  1  quotient not representable (only -2^(WIDTH_DVD-1) / -1)

Behaviour:
- Reset (rst=0, async): state=IDLE. quotient, remainder, busy, ready, div_zero and ovf are all 0. Internal registers and counter are cleared. Reset mid-operation aborts with no ready pulse.
- States: IDLE, DIVIDE, SIGN, DONE.
- IDLE, start=1 at edge E0:
  - Capture |dividend| (WIDTH_DVD-bit unsigned) and |divisor| (WIDTH_DVS-bit unsigned).
  - Capture sign_q = dividend MSB xor divisor MSB, and sign_r = dividend MSB.
  - Clear partial remainder (WIDTH_DVS+1 bits) and bit counter.
  - Set busy=1.
  - Next state is DIVIDE, or DONE if divisor==0.
- DIVIDE, edges E1..E10 (WIDTH_DVD cycles), one restoring step per edge:
  - Shift {partial remainder, quotient register} left by 1, taking the next dividend bit MSB-first.
  - Trial-subtract |divisor|. If the result is non-negative, keep it and set the quotient LSB=1; otherwise restore and set the LSB=0.
  - Counter increments; at count==WIDTH_DVD-1 the next state is SIGN.
- SIGN, edge E11:
  - quotient = sign_q ? -q_mag : q_mag.
  - remainder = sign_r ? -r_mag : r_mag.
  - If q_mag > 2^(WIDTH_DVD-1)-1 and sign_q=0: quotient = 10'h1FF (saturate) and ovf=1; otherwise ovf=0.
  - div_zero=0. Next state is DONE.
- DONE: ready=1 for exactly one cycle (between E11 and E12). At the next edge, ready=0, busy=0, state=IDLE.
- Divide-by-zero path: at E1, quotient=0, remainder=0, div_zero=1, ovf=0, state=DONE. ready is high between E1 and E2.
- Outputs hold the last result until the next completion or reset. They never change during DIVIDE.
- start while busy=1 is ignored with no queuing. dividend and divisor changes after E0 are ignored.
- start held high continuously: IDLE re-samples it one cycle after DONE, so operations run back-to-back with 1 idle cycle between.
- Edge cases:
  - Remainder magnitude is always < |divisor|.
  - Dividend -512 with magnitude 512 fits the unsigned magnitude register.
  - Divisor -16 with magnitude 16 fits the unsigned magnitude register.
- Latency: normal operation 12 edges from E0 to busy low (ready at E11); divide by zero 2 edges (ready at E1).

Test Plan:
1. dividend=100, divisor=7, start pulse at E0 -> ready high only between E11 and E12, quotient=14, remainder=2, ovf=0, div_zero=0; busy 1 from E0 to E12.
2. dividend=-100 (10'h39C), divisor=7 -> quotient=-14 (10'h3F2), remainder=-2 (5'h1E); then 100 / -16 (5'h10) -> quotient=-6 (10'h3FA), remainder=4.
3. dividend=-512 (10'h200), divisor=-1 (5'h1F) -> ovf=1, quotient=10'h1FF; then -512 / 1 -> quotient=10'h200, ovf=0.
4. dividend=37, divisor=0 -> ready between E1 and E2, div_zero=1, quotient=0, remainder=0; next 37/5 -> div_zero=0, quotient=7, remainder=2.
5. start 100/7, pulse start again at E4 with 50/5, change dividend at E3 -> first result 14 r 2 unaffected, no second ready pulse.
6. rst=0 asynchronously mid-DIVIDE (between E5 and E6) -> all outputs 0 immediately, no ready pulse; after release, 9/3 completes with quotient=3, remainder=0.
